// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} imem_ld_state_t;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 word storage: one synchronous write port, one combinational read port.
module imem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];

    // No reset: program contents survive a core reset.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/imem_responder.sv
// Instruction memory with combinational fetch port and a valid/ready program loader.
// Optional: IMEM_LOAD_CHECKSUM_EN adds a running ld_checksum of all loader handshakes.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              i_mem_addr,
    output logic [31:0]              i_mem_rdata,
    output logic                     fetch_fault,
    output logic                     cpu_hold,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    output logic                     ld_done,
    output logic [$clog2(DEPTH):0]   ld_count,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output logic [31:0]              ld_checksum,
`endif
    output logic                     ld_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    imem_ld_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_ld_count;
    logic           r_ld_overflow;
    logic [31:0]    w_off;
    logic [29:0]    w_idx;
    logic           w_ok;
    logic [31:0]    w_arr_rdata;
    logic           w_hs;
    logic           w_room;
    logic           w_we;

    assign w_off = i_mem_addr - BASE_ADDR;
    assign w_idx = w_off[31:2];
    assign w_ok  = (w_off[1:0] == 2'b00) && (w_idx < 30'(DEPTH));

    assign i_mem_rdata = w_ok ? w_arr_rdata : NOP_WORD;
    assign fetch_fault = !w_ok;

    assign w_hs   = (r_state == LOAD) && ld_valid;
    assign w_room = r_ld_count < CW'(DEPTH);
    // Gate with rst so a reset cycle never lands a stray word.
    assign w_we   = w_hs && w_room && !rst;

    imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_ld_count[AW-1:0]),
        .i_wdata (ld_data),
        .i_raddr (w_idx[AW-1:0]),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ld_count    <= '0;
            r_ld_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && ld_start) begin
                r_ld_count    <= '0;
                r_ld_overflow <= 1'b0;
            end else if (w_hs) begin
                if (w_room) r_ld_count    <= r_ld_count + CW'(1);
                else        r_ld_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ld_ready    = 1'b0;
        cpu_hold    = 1'b0;
        ld_done     = 1'b0;
        case (r_state)
            IDLE: if (ld_start) w_state_nxt = LOAD;
            LOAD: begin
                ld_ready = 1'b1;
                cpu_hold = 1'b1;
                if (ld_valid && ld_last) w_state_nxt = DONE;
            end
            DONE: begin
                cpu_hold    = 1'b1;
                ld_done     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ld_count    = r_ld_count;
    assign ld_overflow = r_ld_overflow;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Dropped overflow words still count, so the host can verify what it sent.
    always_ff @(posedge clk) begin
        if (rst)                             r_checksum <= '0;
        else if (r_state == IDLE && ld_start) r_checksum <= '0;
        else if (w_hs)                       r_checksum <= r_checksum + ld_data;
    end

    assign ld_checksum = r_checksum;
`endif
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: random loads and fetches against a word-array model.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int          DEPTH = 16;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   i_mem_addr = BASE;
    logic [31:0]   i_mem_rdata;
    logic          fetch_fault, cpu_hold, ld_ready, ld_done, ld_overflow;
    logic          ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [31:0]   ld_data = '0;
    logic [CW-1:0] ld_count;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0]   ld_checksum;
`endif

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .i_mem_addr(i_mem_addr), .i_mem_rdata(i_mem_rdata),
        .fetch_fault(fetch_fault), .cpu_hold(cpu_hold), .ld_start(ld_start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .ld_done(ld_done), .ld_count(ld_count),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .ld_checksum(ld_checksum),
`endif
        .ld_overflow(ld_overflow)
    );

    // Reference model: phase 0 = idle, 1 = loading, 2 = done-pulse cycle.
    int          m_phase = 0;
    int          m_cnt   = 0;
    bit          m_ovf   = 0;
    logic [31:0] m_cks   = '0;
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];

    typedef struct { int cnt; bit ovf; logic [31:0] cks; } done_t;
    typedef struct { logic [31:0] data; bit fault; } rd_t;
    done_t done_q[$];
    rd_t   rd_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_ovf = 0; m_cks = '0;
        end else begin
            case (m_phase)
                0: if (ld_start) begin
                    m_phase = 1; m_cnt = 0; m_ovf = 0; m_cks = '0;
                end
                1: if (ld_valid) begin
                    m_cks = m_cks + ld_data;
                    if (m_cnt < DEPTH) begin
                        m_mem[m_cnt] = ld_data;
                        m_known[m_cnt] = 1;
                        m_cnt++;
                    end else m_ovf = 1;
                    if (ld_last) begin
                        m_phase = 2;
                        done_q.push_back('{m_cnt, m_ovf, m_cks});
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        done_t d;
        rd_t   r;
        check("cpu_hold", 32'(cpu_hold), 32'(m_phase != 0));
        check("ld_ready", 32'(ld_ready), 32'(m_phase == 1));
        check("ld_count", 32'(ld_count), 32'(m_cnt));
        check("ld_overflow", 32'(ld_overflow), 32'(m_ovf));
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("ld_checksum", ld_checksum, m_cks);
`endif
        if (ld_done) begin
            if (done_q.size() == 0) begin
                check("unexpected_ld_done", 32'(ld_done), 32'd0);
            end else begin
                d = done_q.pop_front();
                check("done_count", 32'(ld_count), 32'(d.cnt));
                check("done_overflow", 32'(ld_overflow), 32'(d.ovf));
`ifdef IMEM_LOAD_CHECKSUM_EN
                check("done_checksum", ld_checksum, d.cks);
`endif
            end
        end
        if (rd_q.size() != 0) begin
            r = rd_q.pop_front();
            check("fetch_rdata", i_mem_rdata, r.data);
            check("fetch_fault", 32'(fetch_fault), 32'(r.fault));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch address; expectation from plain address arithmetic on the model.
    task automatic issue_read(input logic [31:0] addr);
        logic [31:0] off;
        bit          flt;
        int          idx;
        i_mem_addr = addr;
        off = addr - BASE;
        flt = (off % 4 != 0) || ((off / 4) >= DEPTH);
        idx = int'(off / 4);
        if (flt) rd_q.push_back('{32'h0, 1'b1});
        else if (m_known[idx]) rd_q.push_back('{m_mem[idx], 1'b0});
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = BASE + 4 * $urandom_range(0, DEPTH + 2);
        if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
        if ($urandom_range(0, 15) == 0) a = $urandom;
        return a;
    endfunction

    task automatic load(input logic [31:0] words[$], input bit gaps);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < words.size(); i++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                ld_valid = 1'b0;
                ld_start = 1'($urandom_range(0, 1));
                issue_read(rand_addr());
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = words[i];
            ld_last  = (i == words.size() - 1);
            if (gaps) issue_read(rand_addr());
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] w[$];
        tick(); tick();
        rst = 1'b0;
        tick();

        // Valid traffic while idle must not write anything.
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'($urandom_range(0, 1));
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        issue_read(BASE); tick();

        w = '{32'h20080005, 32'h20090007, 32'h01095020};
        load(w, 1'b0);
        issue_read(32'h0040_0008); tick();
        issue_read(32'h0040_0000); tick();

        issue_read(32'h0040_0002); tick();
        issue_read(32'h003F_FFFC); tick();
        issue_read(BASE + 4 * DEPTH); tick();

        w.delete();
        for (int i = 0; i < DEPTH + 2; i++) w.push_back($urandom);
        load(w, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            issue_read(BASE + 4 * i); tick();
        end

        // Reset after two of five words: partial words stay readable.
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = 32'hA5A5_0000 + i; tick();
        end
        rst = 1'b1; tick();
        rst = 1'b0; ld_valid = 1'b0;
        issue_read(BASE); tick();
        issue_read(BASE + 4); tick();

        for (int s = 0; s < 20; s++) begin
            w.delete();
            for (int i = 0; i < $urandom_range(1, DEPTH + 4); i++) w.push_back($urandom);
            load(w, 1'b1);
            for (int i = 0; i < 6; i++) begin
                issue_read(rand_addr()); tick();
            end
        end

`ifdef IMEM_LOAD_CHECKSUM_EN
        w = '{32'hFFFF_FFFF, 32'h0000_0002};
        load(w, 1'b0);
        check("checksum_value", ld_checksum, 32'h0000_0001);
        rst = 1'b1; tick(); rst = 1'b0;
        check("checksum_reset", ld_checksum, 32'h0);
`endif

        repeat (4) tick();
        check("done_queue_drained", 32'(done_q.size()), 32'd0);
        check("read_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
